demux1to8_tdm: RTL and testbench

//  Receive end of an 8:1 time-division link. An upstream 8:1 mux serialises channels i0..i7

---
 rtl/demux1to8_tdm_if.sv | 35 +++
 rtl/demux1to8_tdm.sv | 113 +++++++++++
 tb/tb_demux1to8_tdm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/demux1to8_tdm_if.sv
// Lane/channel bundle for the 8:1 TDM receive block.
// Optional parity port is present only when DEMUX_PARITY_EN is defined.
interface demux1to8_tdm_if #(
    parameter int W = 1
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_start;
    logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [2:0]   s;
    logic         locked;
    logic         frame_done;
    logic         sync_err;
`ifdef DEMUX_PARITY_EN
    logic         parity_err;

    modport master (
        output din, din_valid, frame_start,
        input  y0, y1, y2, y3, y4, y5, y6, y7, s, locked, frame_done, sync_err, parity_err
    );
    modport slave (
        input  din, din_valid, frame_start,
        output y0, y1, y2, y3, y4, y5, y6, y7, s, locked, frame_done, sync_err, parity_err
    );
`else
    modport master (
        output din, din_valid, frame_start,
        input  y0, y1, y2, y3, y4, y5, y6, y7, s, locked, frame_done, sync_err
    );
    modport slave (
        input  din, din_valid, frame_start,
        output y0, y1, y2, y3, y4, y5, y6, y7, s, locked, frame_done, sync_err
    );
`endif
endinterface

// File: rtl/demux1to8_tdm.sv
// Receive end of an 8:1 TDM lane: frame alignment, shadow collection and
// once-per-frame parallel update of y0..y7, with re-sync error reporting.
// Macro DEMUX_PARITY_EN adds a 9th slot carrying the XOR of slots 0..7;
// a mismatching frame is discarded and flagged on parity_err.
module demux1to8_tdm #(
    parameter int W = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    demux1to8_tdm_if.slave  bus
);
`ifdef DEMUX_PARITY_EN
    localparam int CW  = 4;
    localparam int NSH = 8;   // slot 8 is checked straight from din
`else
    localparam int CW  = 3;
    localparam int NSH = 7;   // slot 7 goes straight from din to y7
`endif
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSH);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]               r_state;
    logic [CW-1:0]            r_cnt;
    logic [NSH-1:0][W-1:0]    r_shadow;
    logic [7:0][W-1:0]        r_y;
    logic                     r_frame_done;
    logic                     r_sync_err;
    logic                     w_resync;
`ifdef DEMUX_PARITY_EN
    logic                     r_parity_err;
    logic [W-1:0]             w_par;

    // Running XOR of the collected data slots, compared against slot 8.
    always_comb begin
        w_par = '0;
        for (int i = 0; i < 8; i++) w_par = w_par ^ r_shadow[i];
    end
`endif

    // frame_start mid-frame while locked restarts the frame at slot 0.
    assign w_resync = (r_state == ST_LOCKED) && bus.frame_start && (r_cnt != '0);

    // Framing FSM, slot counter, shadow bank and output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
`ifdef DEMUX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
`ifdef DEMUX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (bus.din_valid) begin
                if (r_state == ST_HUNT) begin
                    if (bus.frame_start) begin
                        r_shadow[0] <= bus.din;
                        r_cnt       <= CNT_ONE;
                        r_state     <= ST_LOCKED;
                    end
                end else if (w_resync) begin
                    r_sync_err  <= 1'b1;
                    r_shadow    <= '0;
                    r_shadow[0] <= bus.din;
                    r_cnt       <= CNT_ONE;
                end else if (r_cnt == CNT_LAST) begin
                    r_cnt <= '0;
`ifdef DEMUX_PARITY_EN
                    if (bus.din == w_par) begin
                        r_y          <= r_shadow;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_parity_err <= 1'b1;
                    end
`else
                    r_y          <= {bus.din, r_shadow};
                    r_frame_done <= 1'b1;
`endif
                end else begin
                    for (int i = 0; i < NSH; i++)
                        if (r_cnt == CW'(i)) r_shadow[i] <= bus.din;
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign bus.y0         = r_y[0];
    assign bus.y1         = r_y[1];
    assign bus.y2         = r_y[2];
    assign bus.y3         = r_y[3];
    assign bus.y4         = r_y[4];
    assign bus.y5         = r_y[5];
    assign bus.y6         = r_y[6];
    assign bus.y7         = r_y[7];
    assign bus.s          = r_cnt[2:0];
    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.frame_done = r_frame_done;
    assign bus.sync_err   = r_sync_err;
`ifdef DEMUX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`endif
endmodule

// File: tb/tb_demux1to8_tdm.sv
// Randomised bench for demux1to8_tdm against a frame-level queue model.
module tb_demux1to8_tdm;
    localparam int W = 4;
`ifdef DEMUX_PARITY_EN
    localparam int NS = 9;
`else
    localparam int NS = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    demux1to8_tdm_if #(.W(W)) bus();
    demux1to8_tdm #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: received slots of the current frame, plus visible outputs.
    bit                m_locked;
    logic [W-1:0]      m_q[$];
    logic [7:0][W-1:0] m_y;
    bit                m_fd, m_se, m_pe;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        m_q.delete();
        m_y = '0;
        m_fd = 1'b0; m_se = 1'b0; m_pe = 1'b0;
    endfunction

    function automatic void model_beat(bit v, bit fs, logic [W-1:0] d);
        logic [W-1:0]      p;
        logic [7:0][W-1:0] f;
        m_fd = 1'b0; m_se = 1'b0; m_pe = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                m_q.delete();
                m_q.push_back(d);
            end
        end else if (fs && m_q.size() != 0) begin
            m_se = 1'b1;
            m_q.delete();
            m_q.push_back(d);
        end else begin
            m_q.push_back(d);
            if (m_q.size() == NS) begin
                p = '0;
                for (int i = 0; i < 8; i++) begin
                    f[i] = m_q[i];
                    p    = p ^ m_q[i];
                end
                if (NS == 8 || m_q[NS-1] == p) begin
                    m_y  = f;
                    m_fd = 1'b1;
                end else begin
                    m_pe = 1'b1;
                end
                m_q.delete();
            end
        end
    endfunction

    task automatic check_outs();
        logic [8*W-1:0] got_y;
        got_y = {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
        chk("y", got_y, m_y);
        chk("s", bus.s, m_q.size() % 8);
        chk("locked", bus.locked, m_locked);
        chk("frame_done", bus.frame_done, m_fd);
        chk("sync_err", bus.sync_err, m_se);
        chk("fd_se_excl", bus.frame_done & bus.sync_err, 0);
`ifdef DEMUX_PARITY_EN
        chk("parity_err", bus.parity_err, m_pe);
`endif
    endtask

    // Present one beat, let the edge take it, then check 1 time unit later.
    task automatic beat(bit v, bit fs, logic [W-1:0] d);
        bus.din_valid   = v;
        bus.frame_start = fs;
        bus.din         = d;
        @(posedge clk);
        if (rst_n) model_beat(v, fs, d);
        #1 check_outs();
    endtask

    task automatic idle(int n);
        repeat (n) beat(1'b0, 1'($urandom_range(1)), W'($urandom));
    endtask

    // One aligned frame; optional 3-cycle gap before slot gap_at, random gaps by percentage.
    task automatic send_frame(logic [7:0][W-1:0] f, bit corrupt, int gap_pct, int gap_at);
        logic [W-1:0] p;
        logic [W-1:0] d;
        p = '0;
        for (int i = 0; i < 8; i++) p = p ^ f[i];
        for (int i = 0; i < NS; i++) begin
            if (i == gap_at) idle(3);
            if (int'($urandom_range(99)) < gap_pct) idle($urandom_range(1, 3));
            d = (i < 8) ? f[i] : (p ^ W'(corrupt));
            beat(1'b1, i == 0, d);
        end
    endtask

    // Asynchronous reset pulse away from the clock edge, checked before the next edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outs();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    function automatic logic [7:0][W-1:0] rand_frame();
        logic [7:0][W-1:0] f;
        for (int i = 0; i < 8; i++) f[i] = W'($urandom);
        return f;
    endfunction

    initial begin
        logic [7:0][W-1:0] f;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.din         = '0;
        model_reset();
        #12 check_outs();
        #11 rst_n = 1'b1;

        // Idle after reset
        idle(10);

        // Single basic frame
        f = '0; f[0] = W'(1);
        send_frame(f, 1'b0, 0, -1);

        // Walking one, back-to-back
        for (int k = 0; k < 8; k++) begin
            f = '0; f[k] = W'(1);
            send_frame(f, 1'b0, 0, -1);
        end

        // Gap between slots 3 and 4
        send_frame(rand_frame(), 1'b0, 0, 4);

        // Re-sync at s=5, then a fresh frame
        f = rand_frame();
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, W'($urandom));
        send_frame(f, 1'b0, 0, -1);

        // Async reset at s=3, then unaligned beats are dropped
        for (int i = 0; i < 3; i++) beat(1'b1, i == 0, W'($urandom));
        async_reset();
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, W'($urandom));

        // Corrupted then correct parity word (plain frames without parity)
        send_frame(rand_frame(), 1'b1, 0, -1);
        send_frame(rand_frame(), 1'b0, 0, -1);

        // Random mix
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(9))
                0, 1, 2, 3, 4, 5: send_frame(rand_frame(), ($urandom_range(7) == 0), 20, -1);
                6: repeat ($urandom_range(1, 10))
                       beat(1'($urandom_range(1)), ($urandom_range(3) == 0), W'($urandom));
                7: idle($urandom_range(1, 4));
                8: if ($urandom_range(3) == 0) async_reset();
                default: repeat (3) send_frame(rand_frame(), 1'b0, 0, -1);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
